// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch redirect, data-memory wait and timeout.
// Zero-cycle combinational decisions; the FSM only tracks memory wait length and the sticky error.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT[7:0];

    state_t     cur_state, nxt_state;
    logic [7:0] wait_cnt, wait_nxt;
    logic       err_nxt;
    logic       load_use, mem_stall;

    assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !dmem_ready;
    assign state     = cur_state;

    always_comb begin
        nxt_state    = cur_state;
        wait_nxt     = wait_cnt;
        err_nxt      = mem_err;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;

        if (rst) begin
            // Hold the pipeline empty for as long as reset is asserted.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            case (cur_state)
                RUN, MEMWAIT: begin
                    if (mem_stall) begin
                        // EX is frozen, so branch/load-use are re-evaluated on release.
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                    end else if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end

                    if (cur_state == RUN) begin
                        if (mem_stall) begin
                            nxt_state = MEMWAIT;
                            wait_nxt  = 8'd1;
                        end
                    end else if (mem_stall) begin
                        if (wait_cnt == TIMEOUT_LIM) begin
                            nxt_state = ERR;
                            err_nxt   = 1'b1;
                        end else begin
                            wait_nxt = wait_cnt + 8'd1;
                        end
                    end else begin
                        nxt_state = RUN;
                        wait_nxt  = 8'd0;
                    end
                end
                ERR: begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end
                default: begin
                    nxt_state = RUN;
                    wait_nxt  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state   <= RUN;
            wait_cnt    <= 8'd0;
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            mem_err   <= err_nxt;
            if ((cur_state == RUN || cur_state == MEMWAIT) && !pc_en &&
                (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs driven on the falling edge, outputs sampled 1ns later.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [7:0] C_NORM = 8'b11111_000;
    localparam logic [7:0] C_MSTL = 8'b00001_001;
    localparam logic [7:0] C_BRAN = 8'b11111_110;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_ERR  = 8'b00000_001;
    localparam logic [7:0] C_RST  = 8'b00000_111;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, mem_req, dmem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, memwb_bubble, mem_err;
    logic [1:0]    state;
    logic [CW-1:0] stall_count;
    logic [7:0]    ctrl;

    int errors = 0;
    int checks = 0;

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .mem_err(mem_err), .state(state), .stall_count(stall_count)
    );

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic set_lu();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        idle();
        rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        checks++; if (ctrl !== C_RST) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RST); end
        checks++; if (state !== 2'd0 || mem_err !== 1'b0 || stall_count !== '0) begin
            errors++; $display("FAIL reset_regs state=%0d err=%b cnt=%0d exp 0/0/0", state, mem_err, stall_count); end
        #2 rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL post_reset_ctrl got=%b exp=%b", ctrl, C_NORM); end
    endtask

    task automatic test_load_use();
        pulse_rst();
        @(negedge clk); set_lu(); #1;
        checks++; if (ctrl !== C_LU) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", ctrl, C_LU); end
        @(negedge clk); idle(); #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL lu_after got=%b exp=%b", ctrl, C_NORM); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
        @(negedge clk); ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1; #1;
        checks++; if (ctrl !== C_LU) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", ctrl, C_LU); end
        @(negedge clk); idle();
    endtask

    task automatic test_no_hazard();
        pulse_rst();
        @(negedge clk); ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL x0_no_stall got=%b exp=%b", ctrl, C_NORM); end
        @(negedge clk); ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL unused_src got=%b exp=%b", ctrl, C_NORM); end
        @(negedge clk); ex_memread = 1'b0; id_uses_rs1 = 1'b1; #1;
        checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL not_load got=%b exp=%b", ctrl, C_NORM); end
        @(negedge clk); idle(); #1;
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL no_haz_count got=%0d exp=0", stall_count); end
    endtask

    task automatic test_branch();
        pulse_rst();
        @(negedge clk); ex_branch_taken = 1'b1; #1;
        checks++; if (ctrl !== C_BRAN) begin errors++; $display("FAIL branch got=%b exp=%b", ctrl, C_BRAN); end
        @(negedge clk); set_lu(); #1;
        checks++; if (ctrl !== C_BRAN) begin errors++; $display("FAIL branch_lu got=%b exp=%b", ctrl, C_BRAN); end
        @(negedge clk); idle(); #1;
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL branch_count got=%0d exp=0", stall_count); end
    endtask

    task automatic test_mem_wait();
        pulse_rst();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0; #1;
            checks++; if (ctrl !== C_MSTL) begin errors++; $display("FAIL mw_ctrl%0d got=%b exp=%b", i, ctrl, C_MSTL); end
            checks++; if (state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL mw_state%0d got=%0d exp=%0d", i, state, (i == 0) ? 0 : 1); end
        end
        @(negedge clk); dmem_ready = 1'b1; #1;
        checks++; if (ctrl !== C_NORM || state !== 2'd1) begin
            errors++; $display("FAIL mw_release got=%b/%0d exp=%b/1", ctrl, state, C_NORM); end
        @(negedge clk); idle(); #1;
        checks++; if (state !== 2'd0 || stall_count !== 4'd3) begin
            errors++; $display("FAIL mw_done state=%0d cnt=%0d exp 0/3", state, stall_count); end
    endtask

    task automatic test_stall_priority();
        pulse_rst();
        repeat (2) begin
            @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1; #1;
            checks++; if (ctrl !== C_MSTL) begin errors++; $display("FAIL stall_over_branch got=%b exp=%b", ctrl, C_MSTL); end
        end
        @(negedge clk); dmem_ready = 1'b1; #1;
        checks++; if (ctrl !== C_BRAN) begin errors++; $display("FAIL branch_on_release got=%b exp=%b", ctrl, C_BRAN); end
        @(negedge clk); ex_branch_taken = 1'b0; dmem_ready = 1'b0; set_lu(); #1;
        checks++; if (ctrl !== C_MSTL) begin errors++; $display("FAIL stall_over_lu got=%b exp=%b", ctrl, C_MSTL); end
        @(negedge clk); dmem_ready = 1'b1; #1;
        checks++; if (ctrl !== C_LU) begin errors++; $display("FAIL lu_on_release got=%b exp=%b", ctrl, C_LU); end
        @(negedge clk); idle(); mem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); mem_req = 1'b0; #1;
        checks++; if (ctrl !== C_NORM || state !== 2'd1) begin
            errors++; $display("FAIL abort_ctrl got=%b/%0d exp=%b/1", ctrl, state, C_NORM); end
        @(negedge clk); #1;
        checks++; if (state !== 2'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL abort_state state=%0d err=%b exp 0/0", state, mem_err); end
    endtask

    task automatic test_timeout();
        pulse_rst();
        @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (state !== 2'd1 || mem_err !== 1'b0) begin
            errors++; $display("FAIL to_before state=%0d err=%b exp 1/0", state, mem_err); end
        @(negedge clk); #1;
        checks++; if (state !== 2'd2 || mem_err !== 1'b1) begin
            errors++; $display("FAIL to_enter state=%0d err=%b exp 2/1", state, mem_err); end
        checks++; if (ctrl !== C_ERR) begin errors++; $display("FAIL to_ctrl got=%b exp=%b", ctrl, C_ERR); end
        @(negedge clk); dmem_ready = 1'b1; mem_req = 1'b0; ex_branch_taken = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== 2'd2 || ctrl !== C_ERR || stall_count !== 4'd5) begin
            errors++; $display("FAIL to_sticky state=%0d ctrl=%b cnt=%0d exp 2/%b/5", state, ctrl, stall_count, C_ERR); end
        pulse_rst();
        #1;
        checks++; if (state !== 2'd0 || mem_err !== 1'b0 || stall_count !== 4'd0) begin
            errors++; $display("FAIL to_reset state=%0d err=%b cnt=%0d exp 0/0/0", state, mem_err, stall_count); end
    endtask

    task automatic test_async_reset();
        pulse_rst();
        @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (ctrl !== C_RST || state !== 2'd0 || stall_count !== 4'd0) begin
            errors++; $display("FAIL async_rst ctrl=%b state=%0d cnt=%0d exp %b/0/0", ctrl, state, stall_count, C_RST); end
        idle();
        #1 rst = 1'b0;
    endtask

    task automatic test_saturate();
        pulse_rst();
        @(negedge clk); set_lu();
        repeat (20) @(negedge clk);
        #1;
        checks++; if (stall_count !== 4'hF) begin errors++; $display("FAIL saturate got=%0d exp=15", stall_count); end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_stall_priority();
        test_timeout();
        test_async_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
